ov7670_pixel_capture: RTL

Converts the OV7670 parallel byte stream (VSYNC/HREF/D[7:0], RGB565, high byte first) into the pixel write stream consumed by the ghost (colour-invert) filter: write enable, linear frame address and 16-bit RGB565 word. It is the first stage after the camera pins. It runs on the camera pixel clock, crops each frame to IMG_WIDTH x IMG_HEIGHT, and reports frame completion and frame geometry errors.

---
 rtl/ov7670_pixel_capture.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB565 byte stream to cropped pixel writes (addr = y*IMG_WIDTH+x) with frame status.
// Write strobe one cycle after the low byte edge; camera cannot be stalled, so no backpressure exists.
module ov7670_pixel_capture #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    capture_en,
    input  logic                                    vsync,
    input  logic                                    href,
    input  logic [7:0]                              cam_data,
    output logic                                    we_out,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wAddr_out,
    output logic [15:0]                             wData_out,
    output logic                                    frame_done,
    output logic                                    frame_err
);

    localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int XW = $clog2(IMG_WIDTH + 2);
    localparam int YW = $clog2(IMG_HEIGHT + 2);

    localparam logic [XW-1:0] X_LIM    = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] X_SAT    = XW'(IMG_WIDTH + 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_LIM    = YW'(IMG_HEIGHT);
    localparam logic [YW-1:0] Y_SAT    = YW'(IMG_HEIGHT + 1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_WIDTH);

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_BLANK  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]    state;
    logic          href_d;
    logic          byte_phase;
    logic [7:0]    hi_byte;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [AW-1:0] row_base;
    logic          err_acc;

    logic          pix_step;
    logic          line_end;
    logic          frame_end;
    logic          in_crop;
    logic          line_err;
    logic [XW-1:0] x_inc;
    logic [YW-1:0] y_inc;
    logic [YW-1:0] y_after;
    logic          frame_err_nxt;

    // A frame-end cycle never consumes a byte, so an aborted line leaves no partial pixel.
    always_comb begin
        pix_step      = (state == ST_ACTIVE) && href && !vsync;
        line_end      = (state == ST_ACTIVE) && href_d && !href;
        frame_end     = (state == ST_ACTIVE) && vsync;
        in_crop       = (x_cnt < X_LIM) && (y_cnt < Y_LIM);
        x_inc         = (x_cnt == X_SAT) ? x_cnt : x_cnt + X_ONE;
        y_inc         = (y_cnt == Y_SAT) ? y_cnt : y_cnt + Y_ONE;
        line_err      = line_end && ((x_cnt != X_LIM) || byte_phase);
        y_after       = line_end ? y_inc : y_cnt;
        frame_err_nxt = err_acc || line_err || href || (y_after != Y_LIM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_SYNC;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (vsync) begin
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (!vsync) begin
                        state <= capture_en ? ST_ACTIVE : ST_SYNC;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_end) begin
                        state <= ST_BLANK;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            href_d <= 1'b0;
        end else begin
            href_d <= href;
        end
    end

    // Line/frame counters; the line-end update and the frame-end check may share a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_phase <= 1'b0;
            hi_byte    <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            row_base   <= '0;
            err_acc    <= 1'b0;
        end else if (state == ST_BLANK && !vsync && capture_en) begin
            byte_phase <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            row_base   <= '0;
            err_acc    <= 1'b0;
        end else if (pix_step) begin
            if (!byte_phase) begin
                hi_byte    <= cam_data;
                byte_phase <= 1'b1;
            end else begin
                byte_phase <= 1'b0;
                x_cnt      <= x_inc;
            end
        end else if (line_end) begin
            err_acc    <= err_acc | line_err;
            y_cnt      <= y_inc;
            x_cnt      <= '0;
            byte_phase <= 1'b0;
            if (y_cnt < Y_LIM) begin
                row_base <= row_base + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_out    <= 1'b0;
            wAddr_out <= '0;
            wData_out <= '0;
        end else begin
            we_out <= 1'b0;
            if (pix_step && byte_phase && in_crop) begin
                we_out    <= 1'b1;
                wAddr_out <= row_base + AW'(x_cnt);
                wData_out <= {hi_byte, cam_data};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_err <= frame_err_nxt;
            end
        end
    end

endmodule
